ram_ctrl: RTL and testbench

RAM_CTRL -- requirements
Module: ram_ctrl

---
 rtl/ram_ctrl.sv | 157 +++++++++++++++
 tb/tb_ram_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_ctrl.sv
// Burst controller for a single-port synchronous RAM.
// Reads cost 2 cycles/word, writes at least 3 cycles/word.
module ram_ctrl #(
    parameter int AddrSize = 11,
    parameter int WordSize = 9
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                dir,
    input  logic [AddrSize-1:0] base_addr,
    input  logic [7:0]          len,
    input  logic [WordSize-1:0] wd_data,
    input  logic                wd_valid,
    output logic                wd_ready,
    output logic [WordSize-1:0] rd_data,
    output logic                rd_valid,
    output logic                busy,
    output logic                done,
    output logic [AddrSize-1:0] mem_addr,
    output logic [WordSize-1:0] mem_di,
    input  logic [WordSize-1:0] mem_do,
    output logic                mem_en,
    output logic                mem_we,
    output logic                mem_re
);

    typedef enum logic [2:0] {
        IDLE,
        R_ISSUE,
        R_CAPTURE,
        W_SETUP,
        W_STROBE,
        W_HOLD
    } state_e;

    state_e              state_q;
    logic [AddrSize-1:0] addr_q;
    logic [AddrSize-1:0] addr_d;
    logic [7:0]          cnt_q;
    logic [7:0]          cnt_d;
    logic [AddrSize-1:0] mem_addr_q;
    logic [WordSize-1:0] mem_di_q;
    logic [WordSize-1:0] rd_data_q;
    logic                mem_en_q;
    logic                mem_we_q;
    logic                mem_re_q;
    logic                wd_ready_q;
    logic                rd_valid_q;
    logic                busy_q;
    logic                done_q;

    // Address wraps naturally at 2^AddrSize.
    assign addr_d = addr_q + 1'b1;
    assign cnt_d  = cnt_q - 8'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            cnt_q      <= '0;
            mem_addr_q <= '0;
            mem_di_q   <= '0;
            rd_data_q  <= '0;
            mem_en_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_re_q   <= 1'b0;
            wd_ready_q <= 1'b0;
            rd_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            rd_valid_q <= 1'b0;
            done_q     <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        addr_q <= base_addr;
                        cnt_q  <= len;
                        busy_q <= 1'b1;
                        if (dir) begin
                            wd_ready_q <= 1'b1;
                            state_q    <= W_SETUP;
                        end else begin
                            mem_addr_q <= base_addr;
                            mem_en_q   <= 1'b1;
                            mem_re_q   <= 1'b1;
                            state_q    <= R_ISSUE;
                        end
                    end
                end
                R_ISSUE: begin
                    mem_en_q <= 1'b0;
                    mem_re_q <= 1'b0;
                    state_q  <= R_CAPTURE;
                end
                R_CAPTURE: begin
                    rd_data_q  <= mem_do;
                    rd_valid_q <= 1'b1;
                    if (cnt_q == 8'd0) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        addr_q     <= addr_d;
                        cnt_q      <= cnt_d;
                        mem_addr_q <= addr_d;
                        mem_en_q   <= 1'b1;
                        mem_re_q   <= 1'b1;
                        state_q    <= R_ISSUE;
                    end
                end
                W_SETUP: begin
                    if (wd_valid) begin
                        mem_addr_q <= addr_q;
                        mem_di_q   <= wd_data;
                        mem_en_q   <= 1'b1;
                        mem_we_q   <= 1'b1;
                        wd_ready_q <= 1'b0;
                        state_q    <= W_STROBE;
                    end
                end
                W_STROBE: begin
                    mem_we_q <= 1'b0;
                    mem_en_q <= 1'b0;
                    state_q  <= W_HOLD;
                end
                W_HOLD: begin
                    // mem_addr/mem_di stay put until the next handshake.
                    if (cnt_q == 8'd0) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        addr_q     <= addr_d;
                        cnt_q      <= cnt_d;
                        wd_ready_q <= 1'b1;
                        state_q    <= W_SETUP;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_addr = mem_addr_q;
    assign mem_di   = mem_di_q;
    assign rd_data  = rd_data_q;
    assign mem_en   = mem_en_q;
    assign mem_we   = mem_we_q;
    assign mem_re   = mem_re_q;
    assign wd_ready = wd_ready_q;
    assign rd_valid = rd_valid_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_ram_ctrl.sv
// Directed bench for ram_ctrl with a behavioural RAM and
// scoreboard queues for read data and RAM writes.
module tb_ram_ctrl;

    localparam int AW = 11;
    localparam int DW = 9;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic          dir = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [7:0]    len = '0;
    logic [DW-1:0] wd_data;
    logic          wd_valid;
    logic          wd_ready;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          busy;
    logic          done;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_di;
    logic [DW-1:0] mem_do;
    logic          mem_en;
    logic          mem_we;
    logic          mem_re;

    ram_ctrl #(.AddrSize(AW), .WordSize(DW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .dir(dir),
        .base_addr(base_addr), .len(len),
        .wd_data(wd_data), .wd_valid(wd_valid), .wd_ready(wd_ready),
        .rd_data(rd_data), .rd_valid(rd_valid),
        .busy(busy), .done(done),
        .mem_addr(mem_addr), .mem_di(mem_di), .mem_do(mem_do),
        .mem_en(mem_en), .mem_we(mem_we), .mem_re(mem_re)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] ram [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (mem_en && mem_we) ram[mem_addr] <= mem_di;
        if (mem_en && mem_re) mem_do <= ram[mem_addr];
    end

    int n_chk = 0;
    int n_pass = 0;
    int done_cnt = 0;
    int we_cnt = 0;
    int cyc = 0;
    int last_rv = 0;
    bit rv_run = 0;
    bit pend = 0;
    bit wv_en = 0;
    logic          prev_we = 1'b0;
    logic [AW-1:0] prev_addr = '0;
    logic [DW-1:0] prev_di = '0;

    logic [DW-1:0]    exp_rd[$];
    logic [AW+DW-1:0] exp_wr[$];
    logic [DW-1:0]    wsrc[$];

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Write-data source, scoreboard pops and per-cycle invariants.
    always @(negedge clk) begin
        logic [DW-1:0]    er;
        logic [AW+DW-1:0] ew;
        cyc++;
        if (pend && wsrc.size() != 0) void'(wsrc.pop_front());
        wd_data  = (wsrc.size() != 0) ? wsrc[0] : '0;
        wd_valid = wv_en && (wsrc.size() != 0);
        pend     = wd_ready && wd_valid;
        check("inv_we_re", {31'd0, mem_we & mem_re}, 0);
        check("inv_en", {31'd0, (mem_we | mem_re) & ~mem_en}, 0);
        if (prev_we) begin
            check("we_one_cycle", {31'd0, mem_we}, 0);
            check("addr_stable", {21'd0, mem_addr}, {21'd0, prev_addr});
            check("di_stable", {23'd0, mem_di}, {23'd0, prev_di});
        end
        if (rd_valid) begin
            if (exp_rd.size() == 0) begin
                check("rd_unexpected", 1, 0);
            end else begin
                er = exp_rd.pop_front();
                check("rd_data", {23'd0, rd_data}, {23'd0, er});
            end
            if (rv_run) check("rd_spacing", cyc - last_rv, 2);
            rv_run  = 1;
            last_rv = cyc;
        end
        if (mem_we) begin
            we_cnt++;
            if (exp_wr.size() == 0) begin
                check("wr_unexpected", 1, 0);
            end else begin
                ew = exp_wr.pop_front();
                check("wr_addr_data", {12'd0, mem_addr, mem_di}, {12'd0, ew});
            end
        end
        if (done || !rst_n) rv_run = 0;
        if (done) done_cnt++;
        prev_we   = mem_we;
        prev_addr = mem_addr;
        prev_di   = mem_di;
    end

    // Call at a negedge; runs one burst to its done pulse.
    task automatic burst(input logic d, input logic [AW-1:0] a,
                         input logic [7:0] l, input int exp_cyc,
                         input string tag);
        int c;
        bit got;
        c = 0;
        got = 0;
        start = 1'b1;
        dir = d;
        base_addr = a;
        len = l;
        while (c < 3000) begin
            @(negedge clk);
            c++;
            if (c == 1) start = 1'b0;
            if (done) begin
                got = 1;
                break;
            end
        end
        check({tag, "_done_seen"}, {31'd0, got}, 1);
        check({tag, "_cycles"}, c, exp_cyc);
        check({tag, "_busy_low"}, {31'd0, busy}, 0);
        if (!d) check({tag, "_rv_with_done"}, {31'd0, rd_valid}, 1);
        @(negedge clk);
        check({tag, "_done_pulse"}, {31'd0, done}, 0);
    endtask

    initial begin
        int w0;
        int d0;
        bit got;
        logic [AW-1:0] a;
        for (int i = 0; i < (1 << AW); i++) ram[i] = '0;

        #1 rst_n = 1'b0;
        #2;
        check("rst_mem_addr", {21'd0, mem_addr}, 0);
        check("rst_mem_di", {23'd0, mem_di}, 0);
        check("rst_rd_data", {23'd0, rd_data}, 0);
        check("rst_ctrl", {25'd0, mem_en, mem_we, mem_re, wd_ready,
                           rd_valid, busy, done}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        wv_en = 1;
        wsrc.push_back(9'h1A5);
        exp_wr.push_back({11'h005, 9'h1A5});
        w0 = we_cnt;
        burst(1'b1, 11'h005, 8'd0, 4, "wr1");
        check("wr1_we_cnt", we_cnt - w0, 1);

        exp_rd.push_back(9'h1A5);
        burst(1'b0, 11'h005, 8'd0, 3, "rd1");

        w0 = we_cnt;
        for (int k = 1; k <= 4; k++) begin
            a = 11'h7FE + 11'(k - 1);
            wsrc.push_back(9'(k));
            exp_wr.push_back({a, 9'(k)});
        end
        burst(1'b1, 11'h7FE, 8'd3, 13, "wrap_wr");
        check("wrap_we_cnt", we_cnt - w0, 4);

        for (int k = 1; k <= 4; k++) exp_rd.push_back(9'(k));
        burst(1'b0, 11'h7FE, 8'd3, 9, "wrap_rd");

        // Stall in W_SETUP with ignored start pulses.
        wv_en = 0;
        wsrc.push_back(9'h0AB);
        exp_wr.push_back({11'h010, 9'h0AB});
        d0 = done_cnt;
        start = 1'b1;
        dir = 1'b1;
        base_addr = 11'h010;
        len = 8'd0;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("stall_wd_ready", {31'd0, wd_ready}, 1);
            check("stall_no_access", {30'd0, mem_en, mem_we}, 0);
            start = (i % 2 == 0);
            dir = 1'b0;
            base_addr = 11'h300;
            len = 8'd7;
            @(negedge clk);
        end
        start = 1'b0;
        wv_en = 1;
        got = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) begin
                got = 1;
                break;
            end
        end
        check("stall_done_seen", {31'd0, got}, 1);
        @(negedge clk);
        check("stall_done_cnt", done_cnt - d0, 1);
        check("stall_addr", {21'd0, mem_addr}, 32'h010);
        exp_rd.push_back(9'h0AB);
        burst(1'b0, 11'h010, 8'd0, 3, "rd_stall");

        // Reset while mem_we is high.
        wsrc.push_back(9'h155);
        d0 = done_cnt;
        start = 1'b1;
        dir = 1'b1;
        base_addr = 11'h020;
        len = 8'd0;
        @(negedge clk);
        start = 1'b0;
        got = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #2;
            if (mem_we) begin
                got = 1;
                break;
            end
        end
        check("abort_we_seen", {31'd0, got}, 1);
        rst_n = 1'b0;
        #1;
        check("abort_we_low", {31'd0, mem_we}, 0);
        check("abort_busy_low", {31'd0, busy}, 0);
        check("abort_en_low", {31'd0, mem_en}, 0);
        check("abort_addr_zero", {21'd0, mem_addr}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wv_en = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("abort_idle", {30'd0, mem_en, busy}, 0);
        end
        check("abort_no_done", done_cnt - d0, 0);

        exp_rd.push_back(9'h000);
        burst(1'b0, 11'h020, 8'd0, 3, "rd_abort");
        exp_rd.push_back(9'h002);
        burst(1'b0, 11'h7FF, 8'd0, 3, "rd_7ff");

        check("rd_queue_empty", exp_rd.size(), 0);
        check("wr_queue_empty", exp_wr.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
